bram_test_sequencer: RTL
========================

# bram_test_sequencer

Self-checking sequencer for the dual-port block RAM test harness. On `start` it sweeps every address of the attached RAM through its write port with a deterministic address-derived pattern. It then sweeps every address through its read port and compares each returned word against the expected pattern. It reports completion, pass/fail, an error count and the first failing address. All activity advances only on cycles where the shared `clk_en` strobe is high.

## Interface
- `ADDR_W`, default 10: RAM address width; depth N = 2^ADDR_W.
- `DATA_W`, default 16: RAM data width; must be ≥ ADDR_W.
- `PATTERN`, default 16'hA5A5 (DATA_W bits): XOR key applied to the address to form write data.

Ports:
- `clk`: input, 1 bit. Single clock; all state is on its rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `clk_en`: input, 1 bit. Advance enable; when low, no state changes.
- `start`: input, 1 bit. Run request, sampled in IDLE/DONE when `clk_en`=1.
- `wr_en`: output, 1 bit. RAM write strobe (port A).
- `wr_addr`: output, ADDR_W bits. RAM write address.
- `wr_data`: output, DATA_W bits. RAM write data.
- `rd_en`: output, 1 bit. RAM read strobe (port B).
- `rd_addr`: output, ADDR_W bits. RAM read address.
- `rd_data`: input, DATA_W bits. RAM read data, valid one clock after an edge with `rd_en`=1; the RAM holds it while `rd_en`=0.
- `busy`: output, 1 bit. High in WRITE, READ and DRAIN.
- `done`: output, 1 bit. High in DONE.
- `pass`: output, 1 bit. High in DONE when `err_count`=0.
- `err_count`: output, ADDR_W+1 bits. Number of mismatching reads; cannot overflow, maximum is N.
- `first_err_addr`: output, ADDR_W bits. Address of the first mismatch; 0 if there is none.

## Operation
- Expected data: exp(a) = zero-extend(a) XOR PATTERN.
- State machine, with transitions only on edges where `clk_en`=1:
  - **IDLE**: on `start` go to WRITE; `addr`←0; clear `err_count`, `first_err_addr`, `err_seen`.
  - **WRITE**: write `addr`. If `addr`=N-1, go to READ with `addr`←0; otherwise `addr`←`addr`+1.
  - **READ**: read `addr`. Set `cmp_v`←1 and `cmp_a`←`addr`. If `addr`=N-1, go to DRAIN; otherwise `addr`←`addr`+1.
  - **DRAIN**: perform the final compare, then go to DONE.
  - **DONE**: hold results. On `start`, behave exactly as in IDLE (restart clears results).
- Write/read strobes and addresses:
  - `wr_en` = (state==WRITE) & `clk_en`, combinational.
  - `rd_en` = (state==READ) & `clk_en`, combinational.
  - `wr_addr` = `rd_addr` = `addr` (registered).
  - `wr_data` = exp(`addr`).
- Compare:
  - On an enabled edge with `cmp_v`=1, compare `rd_data` against exp(`cmp_a`).
  - On mismatch, `err_count`++. If `err_seen`=0, also set `first_err_addr`←`cmp_a` and `err_seen`←1.
  - `cmp_v` is cleared on every enabled edge outside READ.
- `start` while busy is ignored. `start` held high in DONE restarts immediately.
- An address wrap from N-1 never re-enters WRITE or READ; the address counter is only reloaded by the state transitions.
- If `rst_n` is asserted mid-run, everything returns to IDLE immediately and no partial results are retained.

## Timing
- Reset values: state=IDLE, `addr`=0, `cmp_v`=0. `wr_en`=`rd_en`=0, `wr_addr`=`rd_addr`=0, `wr_data`=PATTERN, `busy`=`done`=`pass`=0, `err_count`=0, `first_err_addr`=0.
- Latency in enabled edges (E0 is the edge that samples `start`):
  - Writes occur on E1..EN.
  - Reads occur on EN+1..E2N.
  - The last compare and the DRAIN→DONE transition occur at E2N+1.
  - `done`/`pass` are high after E2N+1. For N=1024 that is 2049 enabled edges after E0.
- `busy` is high after E0 through E2N+1 exclusive.
- Disabled cycles (`clk_en`=0) only stretch the schedule:
  - No strobes are issued.
  - No counters change.
  - A pending compare waits; the held `rd_data` remains valid.
- `err_count` and `first_err_addr` are registered and update the edge after the corresponding read.

## Test plan
- **Clean run:** correct RAM model, `clk_en`=1, pulse `start` → `done`=1 after 2049 edges, `pass`=1, `err_count`=0, `first_err_addr`=0; exactly 1024 `wr_en` and 1024 `rd_en` pulses.
- **Single fault:** model flips bit0 of `rd_data` at address 5 → `err_count`=1, `first_err_addr`=5, `pass`=0.
- **Stuck-zero RAM:** PATTERN=0, `rd_data`≡0 → `err_count`=1023, `first_err_addr`=1, `pass`=0.
- **Gated clock:** `clk_en` random at 50% duty → same results as the clean run; `done` after 2049 enabled edges; `wr_en`/`rd_en` never high while `clk_en`=0.
- **Start handling:** `start` pulsed during READ → ignored. After `done`, inject the address-5 fault and pulse `start` → `err_count` clears to 0 then ends at 1; new run of 2049 edges.
- **Reset mid-run:** assert `rst_n`=0 at read address 300 → all outputs return to reset values immediately. Next `start` gives a clean run with `pass`=1.

Source files
------------

// File: rtl/bram_test_sequencer.sv
// bram_test_sequencer: write/read/compare sweep over a dual-port block RAM.
// Every address is written with (address XOR PATTERN), then read back and
// checked; the block reports done/pass, a mismatch count and the first
// failing address. State only advances on edges where clk_en is high.
module bram_test_sequencer #(
  parameter int                 ADDR_W  = 10,
  parameter int                 DATA_W  = 16,
  parameter logic [DATA_W-1:0]  PATTERN = 16'hA5A5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              start,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [ADDR_W:0]   ERR_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  // Expected RAM word for an address: zero-extended address XOR key.
  function automatic logic [DATA_W-1:0] exp_word(input logic [ADDR_W-1:0] a);
    return DATA_W'(a) ^ PATTERN;
  endfunction

  state_t              state_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                cmp_v_r;
  logic [ADDR_W-1:0]   cmp_a_r;
  logic [ADDR_W:0]     err_count_r;
  logic [ADDR_W-1:0]   first_err_addr_r;
  logic                err_seen_r;
  logic                mismatch_s;

  // Read data of the previous read differs from the word it should hold.
  always_comb begin
    mismatch_s = 1'b0;
    if (cmp_v_r) begin
      mismatch_s = (rd_data != exp_word(cmp_a_r));
    end else begin
      mismatch_s = 1'b0;
    end
  end

  // Sequencer FSM plus compare/result bookkeeping; frozen while clk_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= S_IDLE;
      addr_r           <= ZERO_ADDR;
      cmp_v_r          <= 1'b0;
      cmp_a_r          <= ZERO_ADDR;
      err_count_r      <= {(ADDR_W+1){1'b0}};
      first_err_addr_r <= ZERO_ADDR;
      err_seen_r       <= 1'b0;
    end else if (clk_en) begin
      // Compare is independent of state; it also covers the DRAIN edge.
      if (mismatch_s) begin
        err_count_r <= err_count_r + ERR_ONE;
        if (!err_seen_r) begin
          first_err_addr_r <= cmp_a_r;
          err_seen_r       <= 1'b1;
        end
      end
      case (state_r)
        S_IDLE, S_DONE: begin
          cmp_v_r <= 1'b0;
          if (start) begin
            state_r          <= S_WRITE;
            addr_r           <= ZERO_ADDR;
            err_count_r      <= {(ADDR_W+1){1'b0}};
            first_err_addr_r <= ZERO_ADDR;
            err_seen_r       <= 1'b0;
          end
        end
        S_WRITE: begin
          cmp_v_r <= 1'b0;
          if (addr_r == LAST_ADDR) begin
            state_r <= S_READ;
            addr_r  <= ZERO_ADDR;
          end else begin
            addr_r  <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
        S_READ: begin
          cmp_v_r <= 1'b1;
          cmp_a_r <= addr_r;
          if (addr_r == LAST_ADDR) begin
            state_r <= S_DRAIN;
          end else begin
            addr_r  <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
        S_DRAIN: begin
          cmp_v_r <= 1'b0;
          state_r <= S_DONE;
        end
        default: begin
          cmp_v_r <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode: strobes are gated by clk_en so no access is issued on a stalled cycle.
  always_comb begin
    wr_en          = (state_r == S_WRITE) && clk_en;
    rd_en          = (state_r == S_READ) && clk_en;
    wr_addr        = addr_r;
    rd_addr        = addr_r;
    wr_data        = exp_word(addr_r);
    busy           = (state_r == S_WRITE) || (state_r == S_READ) || (state_r == S_DRAIN);
    done           = (state_r == S_DONE);
    pass           = (state_r == S_DONE) && (err_count_r == {(ADDR_W+1){1'b0}});
    err_count      = err_count_r;
    first_err_addr = first_err_addr_r;
  end

endmodule
